// File: rtl/upcounter_ctrl.sv
// Decimal up-counter with STOP/RUN/CLEAR control, a run-status LED and
// coalescing publication of count/run changes to an SPI master via start/busy.
module upcounter_ctrl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_COUNT = 9999,
    parameter int CNT_W     = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run_stop,
    input  logic             i_clear,
    input  logic             i_busy,
    output logic             o_start,
    output logic [15:0]      o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_run
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic [CNT_W-1:0] count_s;
    logic             run_s;
    logic             changed_s;
    logic             fire_s;
    logic             pending_r;

    // Frame layout seen by the SPI master: run flag, a spare zero bit, then the count.
    function automatic logic [15:0] pack_frame(input logic run, input logic [CNT_W-1:0] count);
        logic [13:0] count_ext;
        count_ext = 14'(count);
        return {run, 1'b0, count_ext};
    endfunction

    // Next state, divider and count from the current state and button pulses.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        count_s = o_count;
        case (state_r)
            ST_STOP: begin
                if (i_clear) begin
                    state_s = ST_CLEAR;
                    div_s   = DIV_ZERO;
                    count_s = COUNT_ZERO;
                end else if (i_run_stop) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_RUN: begin
                // The tick still lands when run_stop arrives on the same cycle.
                if (div_r == DIV_LAST) begin
                    div_s = DIV_ZERO;
                    if (o_count == COUNT_LAST) begin
                        count_s = COUNT_ZERO;
                    end else begin
                        count_s = o_count + COUNT_ONE;
                    end
                end else begin
                    div_s   = div_r + DIV_ONE;
                    count_s = o_count;
                end
                if (i_run_stop) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_CLEAR: begin
                state_s = ST_STOP;
            end
            default: begin
                state_s = ST_STOP;
                div_s   = DIV_ZERO;
                count_s = COUNT_ZERO;
            end
        endcase
    end

    // Change detection and the publish condition for the handshake.
    always_comb begin
        run_s     = (state_s == ST_RUN);
        changed_s = (count_s != o_count) || (run_s != o_run);
        fire_s    = pending_r && !i_busy && !o_start;
    end

    // State, counter, LED and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_STOP;
            div_r     <= DIV_ZERO;
            o_count   <= COUNT_ZERO;
            o_run     <= 1'b0;
            o_start   <= 1'b0;
            o_data    <= 16'h0000;
            pending_r <= 1'b1;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            o_count <= count_s;
            o_run   <= run_s;
            o_start <= fire_s;
            // A change registered on the publish edge keeps pending for a later frame.
            if (fire_s) begin
                o_data    <= pack_frame(o_run, o_count);
                pending_r <= changed_s;
            end else begin
                o_data    <= o_data;
                pending_r <= pending_r || changed_s;
            end
        end
    end

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Self-checking bench for upcounter_ctrl: directed scenarios plus random
// button/busy traffic, checked against an elapsed-run-time reference model.
module tb_upcounter_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int MAX_COUNT = 9999;
    localparam int CNT_W     = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_run_stop;
    logic             i_clear;
    logic             i_busy;
    logic             o_start;
    logic [15:0]      o_data;
    logic [CNT_W-1:0] o_count;
    logic             o_run;

    int checks = 0;
    int errors = 0;

    // Reference model: count derives from RUN cycles elapsed since the last clear/reset.
    int          m_cycles;
    bit          m_running;
    bit          m_clearing;
    bit          m_start;
    bit          m_pend;
    logic [15:0] m_data;

    logic [15:0] frames[$];

    upcounter_ctrl #(.TICK_DIV(TICK_DIV), .MAX_COUNT(MAX_COUNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
        .i_busy(i_busy), .o_start(o_start), .o_data(o_data), .o_count(o_count), .o_run(o_run)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        return (m_cycles / TICK_DIV) % (MAX_COUNT + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rs, input bit clr, input bit bsy, input bit rst);
        int old_count;
        bit old_run;
        bit fire;
        bit chg;
        reset      = rst;
        i_run_stop = rs;
        i_clear    = clr;
        i_busy     = bsy;
        @(posedge clk);
        if (rst) begin
            m_cycles = 0; m_running = 0; m_clearing = 0;
            m_start = 0; m_pend = 1; m_data = 16'h0000;
        end else begin
            old_count = m_count();
            old_run   = m_running;
            fire      = m_pend && !bsy && !m_start;
            if (fire) m_data = {old_run, 1'b0, 14'(old_count)};
            if (m_clearing) begin
                m_clearing = 0;
            end else if (m_running) begin
                m_cycles++;
                if (rs) m_running = 0;
            end else if (clr) begin
                m_clearing = 1;
                m_cycles   = 0;
            end else if (rs) begin
                m_running = 1;
            end
            chg     = (m_count() != old_count) || (m_running != old_run);
            m_pend  = fire ? chg : (m_pend || chg);
            m_start = fire;
        end
        #1;
        chk("count", 32'(o_count), 32'(m_count()));
        chk("run", 32'(o_run), 32'(m_running));
        chk("start", 32'(o_start), 32'(m_start));
        chk("data", 32'(o_data), 32'(m_data));
        if (o_start) frames.push_back(o_data);
    endtask

    task automatic idle(input int n, input bit bsy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, bsy, 1'b0);
    endtask

    task automatic run_until(input int target, input bit bsy, input int limit);
        int n;
        n = 0;
        while (o_count != CNT_W'(target) && n < limit) begin
            step(1'b0, 1'b0, bsy, 1'b0);
            n++;
        end
        chk("reach_count", 32'(o_count), 32'(target));
    endtask

    task automatic chk_frames(input string tag, input logic [15:0] exp[$]);
        chk({tag, "_n"}, 32'(frames.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < frames.size(); i++)
            chk(tag, 32'(frames[i]), 32'(exp[i]));
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_start", 32'(o_start), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);

        // Initial frame after release, then silence
        frames.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_start", 32'(o_start), 32'd1);
        idle(6, 1'b0);
        chk_frames("init_frame", '{16'h0000});

        // RUN for 12 cycles then stop
        frames.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk_frames("run_frames", '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h0003});

        // Busy held across ticks 5->8 coalesces to one frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(5, 1'b0, 40);
        idle(2, 1'b0);
        frames.delete();
        run_until(8, 1'b1, 40);
        idle(2, 1'b0);
        chk_frames("coalesce", '{16'h8008});

        // Wrap at MAX_COUNT
        run_until(9998, 1'b0, 50000);
        idle(2, 1'b0);
        frames.delete();
        run_until(0, 1'b0, 20);
        idle(2, 1'b0);
        chk_frames("wrap", '{16'hA70F, 16'h8000});

        // Clear has priority over run_stop in STOP; inputs ignored during CLEAR
        run_until(7, 1'b0, 40);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("stopped_at_7", 32'(o_count), 32'd7);
        frames.delete();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_count", 32'(o_count), 32'd0);
        chk("clear_run", 32'(o_run), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clear_ignores_rs", 32'(o_run), 32'd0);
        idle(3, 1'b0);
        chk_frames("clear_frame", '{16'h0000});

        // Clear ignored in RUN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(2, 1'b0, 40);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_in_run", 32'(o_count), 32'd2);
        run_until(3, 1'b0, 10);

        // Reset mid-RUN with a frame pending
        run_until(5, 1'b0, 40);
        frames.delete();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_start", 32'(o_start), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        chk("mid_rst_run", 32'(o_run), 32'd0);
        idle(4, 1'b0);
        chk_frames("mid_rst_frame", '{16'h0000});

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(7) == 0, $urandom_range(7) == 0,
                 $urandom_range(2) == 0, $urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
